image_streamer: RTL and testbench

IMAGE_STREAMER -- requirements
Module: image_streamer

---
 rtl/image_pkg.sv | 22 ++
 rtl/pix_fifo2.sv | 47 ++++
 rtl/image_streamer.sv | 98 +++++++++
 tb/tb_image_streamer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared frame geometry, FIFO entry layout and streamer state encoding.
package image_pkg;

  localparam int IMG_W       = 240;
  localparam int IMG_H       = 320;
  localparam int IMG_SIZE    = IMG_W * IMG_H;
  localparam int ADDR_WIDTH  = $clog2(IMG_SIZE);
  localparam int PIX_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One FIFO slot: an RGB565 pixel tagged with end-of-frame.
  typedef struct packed {
    logic                 last;
    logic [PIX_WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry pixel FIFO; a write into a full FIFO is accepted when a read happens in the same cycle.
import image_pkg::*;

module pix_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  entry_t     wr_data,
  input  logic       rd_en,
  output entry_t     rd_data,
  output logic [1:0] occupancy
);

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign pop  = rd_en && (count != 2'd0);
  assign push = wr_en && ((count != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too, so the head (and thus pix_data) reads zero out of reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign rd_data   = mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/image_streamer.sv
// Streams one frame from an external synchronous ROM (one-cycle read latency) to a valid/ready pixel sink.
import image_pkg::*;

module image_streamer #(
  parameter int ADDR_WIDTH = image_pkg::ADDR_WIDTH,
  parameter int IMG_SIZE   = image_pkg::IMG_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  output logic [15:0]           pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_SIZE - 1);

  state_t     state;
  state_t     next_state;
  logic       issue;
  logic       in_flight;
  logic       in_flight_last;
  logic       at_last;
  logic       xfer;
  logic [1:0] occupancy;
  logic [2:0] pending;
  entry_t     wr_entry;
  entry_t     head;

  assign xfer    = pix_valid && pix_ready;
  assign at_last = (rom_addr == LAST_ADDR);

  // The slot freed by this cycle's transfer is counted as available, so a steady sink sees no bubbles.
  assign pending = 3'(occupancy) + 3'(in_flight) - 3'(xfer);
  assign issue   = (state == RUN) && (pending < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here uses <= so all of them see the pre-edge values of each other.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: the default is assigned first so no path leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE:    if (start)             next_state = RUN;
      RUN:     if (issue && at_last)  next_state = DRAIN;
      DRAIN:   if (xfer && pix_last)  next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  // The ROM has no enable, so a delayed copy of issue marks which cycles carry requested data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr       <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      done           <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue && at_last;
      done           <= (state == DRAIN) && xfer && pix_last;
      if ((state == IDLE) && start) begin
        rom_addr <= '0;
      end else if (issue && !at_last) begin
        rom_addr <= rom_addr + ADDR_WIDTH'(1);
      end
    end
  end

  assign wr_entry = '{last: in_flight_last, data: rom_data};

  pix_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (in_flight),
    .wr_data   (wr_entry),
    .rd_en     (xfer),
    .rd_data   (head),
    .occupancy (occupancy)
  );

  assign pix_valid = (occupancy != 2'd0);
  assign pix_data  = head.data;
  assign pix_last  = head.last;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_image_streamer.sv
// Bench for image_streamer: a 16-pixel instance for directed scenarios and a default-size instance for a full frame.
module tb_image_streamer;

  localparam int SMALL_N = 16;
  localparam int BIG_N   = 76800;

  logic        clk;
  logic        rst_n;

  logic        start_s, ready_s, valid_s, last_s, busy_s, done_s;
  logic [16:0] addr_s;
  logic [15:0] rom_s, data_s;

  logic        start_b, ready_b, valid_b, last_b, busy_b, done_b;
  logic [16:0] addr_b;
  logic [15:0] rom_b, data_b;

  int n_checks = 0;
  int n_errors = 0;

  // Small-frame model state
  bit        m_busy, m_done_exp, m_stall, m_prev_last;
  int        m_idx, m_since, s_xfers, first_valid, n_done_s;
  logic [15:0] m_prev_data;

  // Full-frame model state
  bit        b_busy, b_done_exp;
  int        b_idx, b_since, b_xfers, b_latency;
  logic [15:0] b_last_data;
  bit        b_last_tag;

  image_streamer #(.ADDR_WIDTH(17), .IMG_SIZE(SMALL_N)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .rom_addr(addr_s), .rom_data(rom_s),
    .pix_data(data_s), .pix_valid(valid_s), .pix_ready(ready_s), .pix_last(last_s),
    .busy(busy_s), .done(done_s)
  );

  image_streamer dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rom_addr(addr_b), .rom_data(rom_b),
    .pix_data(data_b), .pix_valid(valid_b), .pix_ready(ready_b), .pix_last(last_b),
    .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] big_pix(input int i);
    return 16'(i * 3);
  endfunction

  // Synchronous ROM models: mem[i] = i for the small frame, 3*i for the full frame.
  always @(posedge clk) begin
    rom_s <= (addr_s < 17'(SMALL_N)) ? 16'(addr_s) : 16'hDEAD;
    rom_b <= big_pix(int'(addr_b));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is the ordered list 0..N-1 handed out one per handshake, starting 2 edges after start.
  always @(negedge clk) begin : cmp
    bit acc, xf;
    if (!rst_n) begin
      check("rst_valid", valid_s, 1'b0);
      check("rst_busy", busy_s, 1'b0);
      m_busy = 0; m_done_exp = 0; m_stall = 0; m_idx = 0; m_since = 0;
      b_busy = 0; b_done_exp = 0; b_idx = 0; b_since = 0;
    end else begin
      check("busy", busy_s, m_busy);
      check("done", done_s, m_done_exp);
      check("addr_bound", addr_s <= 17'(SMALL_N - 1), 1'b1);
      if (m_stall) begin
        check("stall_valid", valid_s, 1'b1);
        check("stall_data", data_s, m_prev_data);
        check("stall_last", last_s, m_prev_last);
      end
      if (!m_busy || m_since < 2) check("valid_idle", valid_s, 1'b0);
      else if (m_idx == 0 && m_since == 2) check("valid_first", valid_s, 1'b1);
      if (valid_s && m_busy) begin
        check("data", data_s, 16'(m_idx));
        check("last", last_s, m_idx == SMALL_N - 1);
        if (first_valid < 0) first_valid = m_since;
      end
      if (done_s) n_done_s++;
      acc = start_s && !m_busy;
      xf  = valid_s && ready_s && m_busy;
      m_done_exp  = xf && (m_idx == SMALL_N - 1);
      m_stall     = valid_s && !ready_s;
      m_prev_data = data_s;
      m_prev_last = last_s;
      if (xf) begin
        s_xfers++;
        if (m_idx == SMALL_N - 1) m_busy = 0;
        m_idx++;
      end
      m_since++;
      if (acc) begin
        m_busy = 1; m_idx = 0; m_since = 0; s_xfers = 0; first_valid = -1;
      end

      check("b_busy", busy_b, b_busy);
      check("b_done", done_b, b_done_exp);
      if (!b_busy) check("b_valid_idle", valid_b, 1'b0);
      if (valid_b && b_busy) begin
        check("b_data", data_b, big_pix(b_idx));
        check("b_last", last_b, b_idx == BIG_N - 1);
      end
      if (done_b) b_latency = b_since;
      acc = start_b && !b_busy;
      xf  = valid_b && ready_b && b_busy;
      b_done_exp = xf && (b_idx == BIG_N - 1);
      if (xf) begin
        b_xfers++;
        if (b_idx == BIG_N - 1) begin
          b_busy = 0; b_last_data = data_b; b_last_tag = last_b;
        end
        b_idx++;
      end
      b_since++;
      if (acc) begin
        b_busy = 1; b_idx = 0; b_since = 0; b_xfers = 0;
      end
    end
  end

  task automatic pulse_start_s();
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
  endtask

  task automatic wait_done_s(input int limit, input bit rand_ready);
    int cyc = 0;
    while (!done_s && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      if (rand_ready) ready_s = 1'($urandom_range(0, 1));
    end
    check("done_timeout", done_s, 1'b1);
  endtask

  initial begin
    int base, cyc;
    rst_n = 1'b1; start_s = 1'b0; start_b = 1'b0; ready_s = 1'b1; ready_b = 1'b1;
    first_valid = -1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_addr", addr_s, 17'd0);
    check("reset_valid", valid_s, 1'b0);
    check("reset_last", last_s, 1'b0);
    check("reset_data", data_s, 16'h0000);
    check("reset_busy", busy_s, 1'b0);
    check("reset_done", done_s, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full-rate frame
    base = n_done_s;
    pulse_start_s();
    wait_done_s(100, 0);
    repeat (3) @(posedge clk);
    #1;
    check("a_first_valid", first_valid, 2);
    check("a_xfers", s_xfers, SMALL_N);
    check("a_done_pulses", n_done_s - base, 1);

    // Randomly stalling sink
    pulse_start_s();
    wait_done_s(400, 1);
    ready_s = 1'b1;
    check("b_xfers_rand", s_xfers, SMALL_N);
    repeat (2) @(posedge clk);
    #1;

    // Sink held off for 10 cycles
    ready_s = 1'b0;
    pulse_start_s();
    repeat (10) @(posedge clk);
    #1;
    check("c_addr_sat", addr_s, 17'd2);
    check("c_valid_sat", valid_s, 1'b1);
    check("c_head_sat", data_s, 16'h0000);
    ready_s = 1'b1;
    @(posedge clk); #1;
    check("c_b2b_1", data_s, 16'h0001);
    @(posedge clk); #1;
    check("c_b2b_valid", valid_s, 1'b1);
    check("c_b2b_2", data_s, 16'h0002);
    wait_done_s(100, 0);
    repeat (2) @(posedge clk);
    #1;

    // start while busy, then start in the done cycle
    pulse_start_s();
    repeat (3) @(posedge clk);
    #1;
    pulse_start_s();
    wait_done_s(100, 0);
    check("d_len", s_xfers, SMALL_N);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    check("d_restart_busy", busy_s, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("d_restart_valid", valid_s, 1'b1);
    check("d_restart_pix", data_s, 16'h0000);
    wait_done_s(100, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame after 5 transfers
    pulse_start_s();
    cyc = 0;
    while (s_xfers < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("e_reach5", s_xfers, 5);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_valid", valid_s, 1'b0);
    check("e_rst_busy", busy_s, 1'b0);
    check("e_rst_done", done_s, 1'b0);
    check("e_rst_addr", addr_s, 17'd0);
    check("e_rst_data", data_s, 16'h0000);
    check("e_rst_last", last_s, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("e_quiet_valid", valid_s, 1'b0);
    check("e_quiet_busy", busy_s, 1'b0);
    pulse_start_s();
    wait_done_s(100, 0);
    check("e_len", s_xfers, SMALL_N);
    check("e_first_valid", first_valid, 2);
    repeat (2) @(posedge clk);
    #1;

    // Full default-size frame
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 80000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("f_done_timeout", done_b, 1'b1);
    @(negedge clk); #1;
    check("f_xfers", b_xfers, BIG_N);
    check("f_last_data", b_last_data, 16'h83FD);
    check("f_last_tag", b_last_tag, 1'b1);
    check("f_latency", b_latency, 76802);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
